// File: rtl/yadro_equation_arbiter.sv
// Round-robin front end sharing one pipelined yadro_equation datapath among N_REQ requesters.
// Optional sticky stale-result error output enabled by defining YADRO_ARB_ERR_EN.
module yadro_equation_arbiter #(
    parameter  int WIDTH     = 32,
    parameter  int N_REQ     = 4,
    parameter  int TAG_DEPTH = 8,
    localparam int ID_W      = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_vld,
    output logic [N_REQ-1:0]       req_rdy,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*WIDTH-1:0] req_c,
    input  logic [N_REQ*WIDTH-1:0] req_d,
    output logic                   eq_arg_vld,
    output logic [WIDTH-1:0]       eq_a,
    output logic [WIDTH-1:0]       eq_b,
    output logic [WIDTH-1:0]       eq_c,
    output logic [WIDTH-1:0]       eq_d,
    input  logic                   eq_res_vld,
    input  logic [WIDTH-1:0]       eq_res,
    output logic                   rsp_vld,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_res
`ifdef YADRO_ARB_ERR_EN
    ,
    output logic                   err
`endif
);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    logic [ID_W-1:0]  rr_q, rr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  tag_q [TAG_DEPTH];
    logic [ID_W-1:0]  tag_d [TAG_DEPTH];
    logic             eq_vld_q, eq_vld_d;
    logic [WIDTH-1:0] eq_a_q, eq_a_d, eq_b_q, eq_b_d, eq_c_q, eq_c_d, eq_d_q, eq_d_d;
    logic             rsp_vld_q, rsp_vld_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_res_q, rsp_res_d;

    logic            found, xfer, pop;
    logic [ID_W-1:0] win, idx;

    // First requesting index at or after the RR pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(rr_q) + k) % N_REQ);
            if (!found && req_vld[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Grant is based on the registered count, so a same-cycle pop never unblocks a full FIFO.
    assign xfer = found && rst_n && (cnt_q < CNT_W'(TAG_DEPTH));
    assign pop  = eq_res_vld && (cnt_q != '0);

    always_comb begin
        req_rdy = '0;
        if (xfer) req_rdy[win] = 1'b1;
    end

    always_comb begin
        rr_d      = rr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        tag_d     = tag_q;
        eq_vld_d  = xfer;
        eq_a_d    = eq_a_q;
        eq_b_d    = eq_b_q;
        eq_c_d    = eq_c_q;
        eq_d_d    = eq_d_q;
        rsp_vld_d = pop;
        rsp_id_d  = rsp_id_q;
        rsp_res_d = rsp_res_q;
        if (xfer) begin
            tag_d[wr_ptr_q] = win;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            rr_d            = (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
            eq_a_d          = req_a[int'(win)*WIDTH +: WIDTH];
            eq_b_d          = req_b[int'(win)*WIDTH +: WIDTH];
            eq_c_d          = req_c[int'(win)*WIDTH +: WIDTH];
            eq_d_d          = req_d[int'(win)*WIDTH +: WIDTH];
        end
        if (pop) begin
            rsp_id_d  = tag_q[rd_ptr_q];
            rsp_res_d = eq_res;
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        end
        case ({xfer, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
            eq_vld_q  <= 1'b0;
            eq_a_q    <= '0;
            eq_b_q    <= '0;
            eq_c_q    <= '0;
            eq_d_q    <= '0;
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= '0;
            rsp_res_q <= '0;
        end else begin
            rr_q      <= rr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            tag_q     <= tag_d;
            eq_vld_q  <= eq_vld_d;
            eq_a_q    <= eq_a_d;
            eq_b_q    <= eq_b_d;
            eq_c_q    <= eq_c_d;
            eq_d_q    <= eq_d_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
            rsp_res_q <= rsp_res_d;
        end
    end

    assign eq_arg_vld = eq_vld_q;
    assign eq_a       = eq_a_q;
    assign eq_b       = eq_b_q;
    assign eq_c       = eq_c_q;
    assign eq_d       = eq_d_q;
    assign rsp_vld    = rsp_vld_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_res    = rsp_res_q;

`ifdef YADRO_ARB_ERR_EN
    logic err_q, err_d;

    // A result with no outstanding tag is left over from before a reset.
    always_comb err_d = err_q | (eq_res_vld && (cnt_q == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`endif
endmodule

// File: tb/tb_yadro_equation_arbiter.sv
// Random-stimulus scoreboard bench for yadro_equation_arbiter with a behavioural datapath stand-in.
`timescale 1ns/1ps
module tb_yadro_equation_arbiter;
    localparam int WIDTH = 32, N_REQ = 4, TAG_DEPTH = 8, ID_W = 2, LAT = 4;

    typedef struct { logic [31:0] a, b, c, d; } ops_t;
    typedef struct { int id; ops_t o; } pend_t;
    typedef struct { int due; logic [31:0] res; } dp_t;
    typedef struct { int id; logic [31:0] res; } rsp_t;

    logic                   clk = 1'b0, rst_n = 1'b0;
    logic [N_REQ-1:0]       req_vld = '0, req_rdy;
    logic [N_REQ*WIDTH-1:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
    logic                   eq_arg_vld, eq_res_vld = 1'b0, rsp_vld;
    logic [WIDTH-1:0]       eq_a, eq_b, eq_c, eq_d, eq_res = '0, rsp_res;
    logic [ID_W-1:0]        rsp_id;
`ifdef YADRO_ARB_ERR_EN
    logic                   err;
`endif

    yadro_equation_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .eq_arg_vld(eq_arg_vld), .eq_a(eq_a), .eq_b(eq_b), .eq_c(eq_c), .eq_d(eq_d),
        .eq_res_vld(eq_res_vld), .eq_res(eq_res),
        .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_res(rsp_res)
`ifdef YADRO_ARB_ERR_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    pend_t pend[$];       // operand sets waiting at requester ports, oldest first
    ops_t  exp_issue[$];  // operands expected on the datapath, in grant order
    rsp_t  exp_rsp[$];    // responses expected from the arbiter
    dp_t   dp_q[$];       // results inside the stand-in datapath
    int    m_ids[$];      // model of outstanding requester IDs
    int    dut_grants[$];
    int    rr = 0, cyc = 0, checks = 0, errors = 0, rsp_seen = 0;
    bit    stall = 1'b0;
    ops_t  mon_e;
    rsp_t  mon_r;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] f(ops_t o);
        return o.a * o.b + o.c - o.d;
    endfunction

    task automatic add_req(int id);
        pend_t p;
        p.id = id; p.o.a = $urandom; p.o.b = $urandom; p.o.c = $urandom; p.o.d = $urandom;
        pend.push_back(p);
    endtask

    // One cycle: datapath stand-in, requester drive, grant/response model, req_rdy check.
    task automatic step();
        int w, j;
        int hd[N_REQ];
        ops_t o;
        dp_t  dp;
        rsp_t r;
        logic [N_REQ-1:0] er;
        @(negedge clk);
        cyc++;
        if (rst_n && eq_arg_vld) begin
            o.a = eq_a; o.b = eq_b; o.c = eq_c; o.d = eq_d;
            dp.due = cyc + LAT; dp.res = f(o);
            dp_q.push_back(dp);
        end
        for (int i = 0; i < N_REQ; i++) hd[i] = -1;
        for (int k = pend.size() - 1; k >= 0; k--) hd[pend[k].id] = k;
        req_vld = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (hd[i] >= 0) begin
                req_vld[i] = 1'b1;
                req_a[i*WIDTH +: WIDTH] = pend[hd[i]].o.a;
                req_b[i*WIDTH +: WIDTH] = pend[hd[i]].o.b;
                req_c[i*WIDTH +: WIDTH] = pend[hd[i]].o.c;
                req_d[i*WIDTH +: WIDTH] = pend[hd[i]].o.d;
            end
        end
        w = -1;
        if (rst_n && m_ids.size() < TAG_DEPTH)
            for (int k = 0; k < N_REQ; k++) begin
                j = (rr + k) % N_REQ;
                if (w < 0 && hd[j] >= 0) w = j;
            end
        eq_res_vld = 1'b0;
        if (!stall && dp_q.size() > 0 && dp_q[0].due <= cyc) begin
            eq_res_vld = 1'b1;
            eq_res     = dp_q[0].res;
            if (rst_n && m_ids.size() > 0) begin
                r.id = m_ids.pop_front(); r.res = dp_q[0].res;
                exp_rsp.push_back(r);
            end
            void'(dp_q.pop_front());
        end
        if (w >= 0) begin
            m_ids.push_back(w);
            exp_issue.push_back(pend[hd[w]].o);
            pend.delete(hd[w]);
            rr = (w + 1) % N_REQ;
        end
        #1;
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        chk("req_rdy", req_rdy, er);
        for (int i = 0; i < N_REQ; i++) if (req_rdy[i]) dut_grants.push_back(i);
    endtask

    task automatic do_reset(int n);
        rst_n = 1'b0;
        m_ids.delete(); exp_issue.delete(); exp_rsp.delete(); pend.delete();
        rr = 0;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        stall = 1'b0;
        while ((pend.size() + m_ids.size() + exp_rsp.size() + exp_issue.size() + dp_q.size()) != 0
               && n < 300) begin
            step();
            n++;
        end
        chk("drain_in_time", n < 300, 1'b1);
    endtask

    // Scoreboard monitor: datapath issue and arbiter responses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (eq_arg_vld) begin
                if (exp_issue.size() == 0) chk("issue_unexpected", eq_arg_vld, 1'b0);
                else begin
                    mon_e = exp_issue.pop_front();
                    chk("eq_a", eq_a, mon_e.a); chk("eq_b", eq_b, mon_e.b);
                    chk("eq_c", eq_c, mon_e.c); chk("eq_d", eq_d, mon_e.d);
                end
            end
            if (rsp_vld) begin
                rsp_seen++;
                if (exp_rsp.size() == 0) chk("rsp_unexpected", rsp_vld, 1'b0);
                else begin
                    mon_r = exp_rsp.pop_front();
                    chk("rsp_id", rsp_id, mon_r.id);
                    chk("rsp_res", rsp_res, mon_r.res);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, r0;
        pend_t p;
        #2;
        chk("rst_req_rdy", req_rdy, 0); chk("rst_eq_arg_vld", eq_arg_vld, 0);
        chk("rst_eq_a", eq_a, 0); chk("rst_eq_d", eq_d, 0);
        chk("rst_rsp_vld", rsp_vld, 0); chk("rst_rsp_id", rsp_id, 0); chk("rst_rsp_res", rsp_res, 0);
`ifdef YADRO_ARB_ERR_EN
        chk("rst_err", err, 0);
`endif
        do_reset(2);

        // Single request from requester 2
        p.id = 2; p.o.a = 5; p.o.b = 1; p.o.c = 2; p.o.d = 3;
        pend.push_back(p);
        drain();

        // Fairness from RR pointer 0
        do_reset(1);
        for (int k = 0; k < 2; k++) for (int i = 0; i < N_REQ; i++) add_req(i);
        g0 = dut_grants.size();
        drain();
        for (int k = 0; k < 8; k++) chk("fair_order", dut_grants[g0 + k], k % 4);

        // Full FIFO with the datapath stalled
        stall = 1'b1;
        for (int k = 0; k < 9; k++) add_req($urandom_range(0, N_REQ - 1));
        g0 = dut_grants.size();
        repeat (14) step();
        chk("full_accepted", dut_grants.size() - g0, 8);
        drain();
        chk("full_total", dut_grants.size() - g0, 9);

        // Push and pop together with three outstanding
        stall = 1'b1;
        for (int i = 0; i < 3; i++) add_req(i);
        repeat (6) step();
        add_req(3); add_req(3);
        drain();

        // Reset with three ops in flight, then late results
        stall = 1'b1;
        for (int i = 0; i < 3; i++) add_req(i);
        repeat (6) step();
        do_reset(2);
        r0 = rsp_seen;
        drain();
        chk("stale_no_rsp", rsp_seen - r0, 0);
`ifdef YADRO_ARB_ERR_EN
        chk("stale_err", err, 1);
        do_reset(1);
        chk("err_cleared", err, 0);
`endif

        // 20 back-to-back from requester 1 (tag pointers wrap)
        r0 = rsp_seen;
        for (int k = 0; k < 20; k++) add_req(1);
        drain();
        chk("wrap_count", rsp_seen - r0, 20);

        // Random traffic with random datapath stalls
        r0 = rsp_seen;
        g0 = dut_grants.size();
        for (int k = 0; k < 400; k++) begin
            if (pend.size() < 12 && $urandom_range(0, 2) != 0) add_req($urandom_range(0, N_REQ - 1));
            stall = ($urandom_range(0, 3) == 0);
            step();
        end
        drain();
        chk("rand_rsp_count", rsp_seen - r0, dut_grants.size() - g0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
